// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// data-memory wait and optional timeout halt.
//
// Ports: clk, resetl (async active-low); ID/EX/MEM hazard inputs
// (id_rn, id_rm, id_uses_rm, ex_rd, ex_memread, mem_memread,
// mem_memwrite, dmem_ready, mem_branch_taken); per-register load
// enables and flushes, pc_sel_branch, stall_cnt, err_timeout.
// Macro PIPE_HAZARD_CTRL_TIMEOUT_EN adds the memory-wait timeout.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_uses_rm,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic        dmem_ready,
  input  logic        mem_branch_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        pc_sel_branch,
  output logic [31:0] stall_cnt,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    RUN, LOAD_USE, MEM_WAIT, HALT
  } state_t;

  state_t state, state_nx;
  logic   mem_busy;
  logic   lu_hazard;
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  assign mem_busy = (mem_memread | mem_memwrite) & ~dmem_ready;

  // r31 is the zero register: never a real dependency.
  assign lu_hazard = ex_memread & (ex_rd != 5'd31) &
                     ((ex_rd == id_rn) |
                      (id_uses_rm & (ex_rd == id_rm)));

  always_comb begin
    state_nx      = state;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    pc_sel_branch = 1'b0;
    unique case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          {pc_en, ifid_en, idex_en} = 3'b000;
          {exmem_en, memwb_en}      = 2'b00;
          memwb_flush               = 1'b1;
          state_nx = timeout_hit ? HALT : MEM_WAIT;
        end else if (mem_branch_taken) begin
          pc_sel_branch = 1'b1;
          ifid_flush    = 1'b1;
          idex_flush    = 1'b1;
          exmem_flush   = 1'b1;
          state_nx      = RUN;
        end else if (lu_hazard) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          // A wait that just completed returns to RUN directly.
          state_nx   = (state == RUN) ? LOAD_USE : RUN;
        end else begin
          state_nx = RUN;
        end
      end
      LOAD_USE: begin
        if (mem_busy) begin
          {pc_en, ifid_en, idex_en} = 3'b000;
          {exmem_en, memwb_en}      = 2'b00;
          memwb_flush               = 1'b1;
          state_nx                  = MEM_WAIT;
        end else begin
          state_nx = RUN;
        end
      end
      HALT: begin
        {pc_en, ifid_en, idex_en} = 3'b000;
        {exmem_en, memwb_en}      = 2'b00;
      end
      default: state_nx = RUN;
    endcase
    // Reset holds every register in its bubble contents.
    if (!resetl) begin
      {pc_en, ifid_en, idex_en} = 3'b000;
      {exmem_en, memwb_en}      = 2'b00;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      memwb_flush   = 1'b1;
      pc_sel_branch = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!pc_en && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Only meaningful while waiting; RUN never reaches it.
  assign timeout_hit = (state == MEM_WAIT) &&
    ({1'b0, wait_cnt} + 17'd1 == 17'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl)
      wait_cnt <= '0;
    else if (state == MEM_WAIT)
      wait_cnt <= wait_cnt + 16'd1;
    else
      wait_cnt <= '0;
  end

  assign err_timeout = (state == HALT);
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Inputs change at negedge; outputs sampled 1ns later.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        resetl;
  logic [4:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rm, ex_memread;
  logic        mem_memread, mem_memwrite;
  logic        dmem_ready, mem_branch_taken;
  logic        pc_en, ifid_en, idex_en;
  logic        exmem_en, memwb_en;
  logic        ifid_flush, idex_flush;
  logic        exmem_flush, memwb_flush;
  logic        pc_sel_branch, err_timeout;
  logic [31:0] stall_cnt;
  logic [4:0]  en;
  logic [3:0]  fl;

  int n_chk = 0;
  int n_err = 0;

  assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  assign fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetl(resetl),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .dmem_ready(dmem_ready),
    .mem_branch_taken(mem_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .pc_sel_branch(pc_sel_branch),
    .stall_cnt(stall_cnt), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0;
    ex_rd = 5'd0; ex_memread = 1'b0;
    mem_memread = 1'b0; mem_memwrite = 1'b0;
    dmem_ready = 1'b1; mem_branch_taken = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic lu(input logic [4:0] rd, input logic [4:0] rn);
    ex_memread = 1'b1; ex_rd = rd; id_rn = rn;
  endtask

  initial begin
    idle();
    resetl = 1'b0;
    #1;
    chk("rst_en", 32'(en), 32'h00);
    chk("rst_fl", 32'(fl), 32'hF);
    chk("rst_psel", 32'(pc_sel_branch), 32'h0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_err", 32'(err_timeout), 32'h0);
    nxt(); nxt();
    resetl = 1'b1;

    // idle RUN
    nxt(); #1;
    chk("run_en", 32'(en), 32'h1F);
    chk("run_fl", 32'(fl), 32'h0);

    // load-use on rn
    nxt(); lu(5'd3, 5'd3); #1;
    chk("lu_en", 32'(en), 32'h07);
    chk("lu_fl", 32'(fl), 32'h4);
    // inputs unchanged: LOAD_USE must not re-fire
    nxt(); #1;
    chk("lu2_en", 32'(en), 32'h1F);
    chk("lu2_fl", 32'(fl), 32'h0);
    chk("lu2_cnt", stall_cnt, 32'd1);

    // load-use on rm, then rm ignored when not used
    nxt(); idle(); lu(5'd7, 5'd0);
    id_rm = 5'd7; id_uses_rm = 1'b1; #1;
    chk("lurm_en", 32'(en), 32'h07);
    nxt(); idle(); #1;
    nxt(); lu(5'd7, 5'd0); id_rm = 5'd7; #1;
    chk("rm_unused", 32'(en), 32'h1F);
    chk("rm_cnt", stall_cnt, 32'd2);

    // r31 never hazards
    nxt(); idle(); lu(5'd31, 5'd31); #1;
    chk("r31_en", 32'(en), 32'h1F);
    nxt(); idle(); #1;
    chk("r31_cnt", stall_cnt, 32'd2);

    // branch beats load-use, state stays RUN
    nxt(); lu(5'd4, 5'd4); mem_branch_taken = 1'b1; #1;
    chk("br_psel", 32'(pc_sel_branch), 32'h1);
    chk("br_fl", 32'(fl), 32'hE);
    chk("br_en", 32'(en), 32'h1F);
    nxt(); mem_branch_taken = 1'b0; #1;
    chk("br_run", 32'(en), 32'h07);
    nxt(); idle(); #1;
    chk("br_cnt", stall_cnt, 32'd3);

    // memory wait, 4 stall cycles
    nxt(); mem_memread = 1'b1; dmem_ready = 1'b0;
    mem_branch_taken = 1'b1; lu(5'd5, 5'd5); #1;
    chk("mw_psel", 32'(pc_sel_branch), 32'h0);
    chk("mw_en0", 32'(en), 32'h00);
    chk("mw_fl0", 32'(fl), 32'h1);
    mem_branch_taken = 1'b0; ex_memread = 1'b0;
    for (int i = 1; i < 4; i++) begin
      nxt(); #1;
      chk("mw_en", 32'(en), 32'h00);
      chk("mw_fl", 32'(fl), 32'h1);
    end
    nxt(); dmem_ready = 1'b1; mem_branch_taken = 1'b1; #1;
    chk("mw_done_en", 32'(en), 32'h1F);
    chk("mw_done_fl", 32'(fl), 32'hE);
    chk("mw_done_psel", 32'(pc_sel_branch), 32'h1);
    nxt(); idle(); #1;
    chk("mw_cnt", stall_cnt, 32'd7);
    chk("mw_run", 32'(en), 32'h1F);

    // mem busy during LOAD_USE
    nxt(); lu(5'd9, 5'd9); #1;
    chk("lum_lu", 32'(en), 32'h07);
    nxt(); idle(); mem_memwrite = 1'b1; dmem_ready = 1'b0; #1;
    chk("lum_en", 32'(en), 32'h00);
    chk("lum_fl", 32'(fl), 32'h1);
    nxt(); dmem_ready = 1'b1; #1;
    chk("lum_done", 32'(en), 32'h1F);
    nxt(); idle(); #1;
    chk("lum_cnt", stall_cnt, 32'd9);

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
    // timeout: busy cycle + 8 waits, HALT on 10th
    nxt(); mem_memread = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("to_wait_err", 32'(err_timeout), 32'h0);
      chk("to_wait_en", 32'(en), 32'h00);
      nxt();
    end
    #1;
    chk("to_err", 32'(err_timeout), 32'h1);
    chk("to_en", 32'(en), 32'h00);
    chk("to_fl", 32'(fl), 32'h0);
    nxt(); dmem_ready = 1'b1; #1;
    chk("to_hold", 32'(err_timeout), 32'h1);
    resetl = 1'b0; #1;
    chk("to_clr", 32'(err_timeout), 32'h0);
    nxt(); resetl = 1'b1; idle(); #1;
    chk("to_run", 32'(en), 32'h1F);
`endif

    // reset mid-MEM_WAIT, between edges
    nxt(); idle(); mem_memread = 1'b1; dmem_ready = 1'b0;
    nxt(); #1;
    chk("pre_rst_en", 32'(en), 32'h00);
    #2;
    resetl = 1'b0;
    #1;
    chk("mrst_en", 32'(en), 32'h00);
    chk("mrst_fl", 32'(fl), 32'hF);
    chk("mrst_cnt", stall_cnt, 32'd0);
    nxt(); idle(); dmem_ready = 1'b0; lu(5'd6, 5'd6);
    resetl = 1'b1; #1;
    chk("post_rst_run", 32'(en), 32'h07);
    chk("post_rst_fl", 32'(fl), 32'h4);
    nxt(); idle(); #1;
    chk("post_rst_cnt", stall_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the data-memory wait limit in cycles (range 1..65535).
REQ-002 clk  in  1  SHALL be the single rising-edge clock.
REQ-003 resetl  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 id_rn, id_rm  in  5 each  SHALL carry the ID-stage source register numbers; id_uses_rm  in  1  SHALL mark rm as a true operand.
REQ-005 ex_rd  in  5, ex_memread  in  1  SHALL carry the EX-stage destination and load flag.
REQ-006 mem_memread, mem_memwrite  in  1 each  SHALL flag a MEM-stage access; dmem_ready  in  1  SHALL signal access completion.
REQ-007 mem_branch_taken  in  1  SHALL flag a resolved taken branch in MEM (branch&zero or uncond_branch).
REQ-008 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  SHALL be the per-register load enables.
REQ-009 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  SHALL force the register to its reset (bubble) contents.
REQ-010 pc_sel_branch  out  1  SHALL select the MEM-stage branch target into PC.
REQ-011 stall_cnt  out  32  SHALL report total stall cycles; err_timeout  out  1  SHALL flag a memory timeout.

Function
REQ-012 The FSM SHALL have states RUN, LOAD_USE, MEM_WAIT, HALT, held in a registered state variable.
REQ-013 Outputs SHALL be combinational from state and current-cycle inputs (zero-cycle latency).
REQ-014 mem_busy = (mem_memread|mem_memwrite) & !dmem_ready; lu_hazard = ex_memread & ex_rd!=31 & (ex_rd==id_rn | (id_uses_rm & ex_rd==id_rm)).
REQ-015 Priority in RUN SHALL be mem_busy > mem_branch_taken > lu_hazard.
REQ-016 RUN, no event: all enables 1, all flushes 0, pc_sel_branch 0.
REQ-017 RUN & mem_busy: all enables 0, memwb_flush 1, next state MEM_WAIT; branch and hazard ignored this cycle.
REQ-018 MEM_WAIT: enables 0, memwb_flush 1 while !dmem_ready; on dmem_ready, outputs SHALL equal RUN evaluation of the same cycle and next state RUN.
REQ-019 RUN & mem_branch_taken: pc_sel_branch 1, ifid/idex/exmem_flush 1, all enables 1; state stays RUN; a simultaneous lu_hazard SHALL be discarded.
REQ-020 RUN & lu_hazard: pc_en 0, ifid_en 0, idex_flush 1, exmem_en/memwb_en 1, next state LOAD_USE.
REQ-021 LOAD_USE: outputs as RUN-no-event (hazard cannot re-fire), next state RUN; mem_busy here SHALL take REQ-017 behaviour instead.
REQ-022 stall_cnt SHALL increment by 1 each cycle pc_en=0, saturating at 0xFFFFFFFF.
REQ-023 HALT: all enables 0, all flushes 0, err_timeout 1; exit only by reset.

Reset
REQ-024 resetl low SHALL immediately, regardless of clk, force state RUN, stall_cnt 0, wait counter 0, err_timeout 0.
REQ-025 During reset, outputs SHALL be enables 0, flushes 1, pc_sel_branch 0.
REQ-026 Reset asserted mid-MEM_WAIT SHALL abandon the wait; first post-reset cycle SHALL evaluate from RUN.

Configuration
REQ-027 Macro PIPE_HAZARD_CTRL_TIMEOUT_EN SHALL enable a 16-bit wait counter cleared on MEM_WAIT entry and incremented per MEM_WAIT cycle.
REQ-028 With macro: counter reaching TIMEOUT_CYCLES while !dmem_ready SHALL move to HALT next cycle.
REQ-029 Without macro: no counter, HALT unreachable, err_timeout tied 0, MEM_WAIT unbounded.

Verification
REQ-030 ex_memread=1, ex_rd=3, id_rn=3 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt=1.
REQ-031 ex_memread=1, ex_rd=31, id_rn=31 -> no stall, stall_cnt unchanged.
REQ-032 mem_branch_taken=1 with lu_hazard=1 same cycle -> pc_sel_branch=1, ifid/idex/exmem_flush=1, pc_en=1, state RUN.
REQ-033 mem_memread=1, dmem_ready low 4 cycles then high -> enables 0 for 4 cycles, resume on 5th; stall_cnt=4.
REQ-034 Macro on, TIMEOUT_CYCLES=8, dmem_ready stuck low -> err_timeout=1 after 9 cycles, enables held 0; resetl pulse clears.
REQ-035 resetl dropped mid-MEM_WAIT between clock edges -> outputs go to reset values within same cycle, stall_cnt=0.
